// File: rtl/uc_pkg.sv
// Shared opcodes, ALUOp codes and control-bundle types for the pipelined MIPS control unit.
// The optional J-instruction support is enabled by defining UC_PIPE_JUMP_EN.
package uc_pkg;

   localparam int UC_OP_W    = 6;
   localparam int UC_ALUOP_W = 3;
   localparam int UC_RA_W    = 5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_MUL   = 6'b011100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b100;
   localparam logic [2:0] ALU_FUNCT = 3'b101;

   typedef struct packed {
      logic                  reg_dst;
      logic                  alu_src;
      logic [UC_ALUOP_W-1:0] alu_op;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
   } m_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   localparam ex_ctrl_t EX_BUBBLE = '{1'b0, 1'b0, ALU_ADD};
   localparam m_ctrl_t  M_BUBBLE  = '{1'b0, 1'b0, 1'b0};
   localparam wb_ctrl_t WB_BUBBLE = '{1'b0, 1'b0};

   // Register 0 is deliberately not excluded: a load into $0 still stalls a reader of $0.
   function automatic logic reg_match(input logic [UC_RA_W-1:0] load_rt,
                                      input logic [UC_RA_W-1:0] rs,
                                      input logic [UC_RA_W-1:0] rt);
      return (load_rt == rs) || (load_rt == rt);
   endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational main decoder: ID opcode to EX/M/WB control bundles plus an illegal flag.
// With UC_PIPE_JUMP_EN defined, J decodes to a legal bubble; otherwise J is illegal.
module uc_decode
   import uc_pkg::*;
#(
   parameter int OP_W = UC_OP_W
) (
   input  logic            valid,
   input  logic [OP_W-1:0] op,
   output ex_ctrl_t        ex,
   output m_ctrl_t         m,
   output wb_ctrl_t        wb,
   output logic            illegal
);

   // Opcode decode; an invalid ID slot or unknown opcode yields an all-zero bundle.
   always_comb begin
      ex      = EX_BUBBLE;
      m       = M_BUBBLE;
      wb      = WB_BUBBLE;
      illegal = 1'b0;
      if (valid) begin
         case (op)
            OP_RTYPE, OP_MUL: begin
               ex.reg_dst   = 1'b1;
               ex.alu_op    = ALU_FUNCT;
               wb.reg_write = 1'b1;
            end
            OP_LW: begin
               ex.alu_src    = 1'b1;
               ex.alu_op     = ALU_ADD;
               m.mem_read    = 1'b1;
               wb.reg_write  = 1'b1;
               wb.mem_to_reg = 1'b1;
            end
            OP_SW: begin
               ex.alu_src  = 1'b1;
               ex.alu_op   = ALU_ADD;
               m.mem_write = 1'b1;
            end
            OP_BEQ: begin
               ex.alu_op = ALU_SUB;
               m.branch  = 1'b1;
            end
            OP_ADDI: begin
               ex.alu_src   = 1'b1;
               ex.alu_op    = ALU_ADD;
               wb.reg_write = 1'b1;
            end
            OP_ANDI: begin
               ex.alu_src   = 1'b1;
               ex.alu_op    = ALU_AND;
               wb.reg_write = 1'b1;
            end
            OP_ORI: begin
               ex.alu_src   = 1'b1;
               ex.alu_op    = ALU_OR;
               wb.reg_write = 1'b1;
            end
            OP_SLTI: begin
               ex.alu_src   = 1'b1;
               ex.alu_op    = ALU_SLT;
               wb.reg_write = 1'b1;
            end
`ifdef UC_PIPE_JUMP_EN
            OP_J: begin
               illegal = 1'b0;
            end
`endif
            default: begin
               illegal = 1'b1;
            end
         endcase
      end else begin
         illegal = 1'b0;
      end
   end

endmodule

// File: rtl/uc_pipe.sv
// Pipelined MIPS control unit: decodes in ID, carries control through ID/EX, EX/MEM, MEM/WB,
// inserts load-use bubbles and applies branch flushes. UC_PIPE_JUMP_EN adds the id_jump output.
module uc_pipe
   import uc_pkg::*;
#(
   parameter int OP_W    = UC_OP_W,
   parameter int ALUOP_W = UC_ALUOP_W,
   parameter int RA_W    = UC_RA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [OP_W-1:0]    id_op,
   input  logic [RA_W-1:0]    id_rs,
   input  logic [RA_W-1:0]    id_rt,
   input  logic               flush,
   output logic               ex_reg_dst,
   output logic               ex_alu_src,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic [RA_W-1:0]    ex_rt,
   output logic               mem_branch,
   output logic               mem_mem_read,
   output logic               mem_mem_write,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic               stall,
`ifdef UC_PIPE_JUMP_EN
   output logic               id_jump,
`endif
   output logic               illegal_op
);

   ex_ctrl_t  dec_ex;
   m_ctrl_t   dec_m;
   wb_ctrl_t  dec_wb;
   logic      dec_illegal;

   ex_ctrl_t  idex_ex;
   m_ctrl_t   idex_m;
   wb_ctrl_t  idex_wb;
   logic      idex_illegal;
   logic [RA_W-1:0] idex_rt;

   m_ctrl_t   exmem_m;
   wb_ctrl_t  exmem_wb;

   wb_ctrl_t  memwb_wb;

   uc_decode #(
      .OP_W (OP_W)
   ) u_decode (
      .valid   (id_valid),
      .op      (id_op),
      .ex      (dec_ex),
      .m       (dec_m),
      .wb      (dec_wb),
      .illegal (dec_illegal)
   );

   // Load-use hazard; a flush outranks it so the two are never asserted together.
   always_comb begin
      stall = 1'b0;
      if (idex_m.mem_read && id_valid && !flush) begin
         stall = reg_match(idex_rt, id_rs, id_rt);
      end else begin
         stall = 1'b0;
      end
   end

`ifdef UC_PIPE_JUMP_EN
   assign id_jump = id_valid & (id_op == OP_J) & ~stall & ~flush;
`endif

   // Control pipeline registers with reset > flush > stall > advance priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         idex_ex      <= EX_BUBBLE;
         idex_m       <= M_BUBBLE;
         idex_wb      <= WB_BUBBLE;
         idex_illegal <= 1'b0;
         idex_rt      <= '0;
         exmem_m      <= M_BUBBLE;
         exmem_wb     <= WB_BUBBLE;
         memwb_wb     <= WB_BUBBLE;
      end else if (flush) begin
         // The branch sitting in EX/MEM still retires into MEM/WB.
         idex_ex      <= EX_BUBBLE;
         idex_m       <= M_BUBBLE;
         idex_wb      <= WB_BUBBLE;
         idex_illegal <= 1'b0;
         exmem_m      <= M_BUBBLE;
         exmem_wb     <= WB_BUBBLE;
         memwb_wb     <= exmem_wb;
      end else if (stall) begin
         idex_ex      <= EX_BUBBLE;
         idex_m       <= M_BUBBLE;
         idex_wb      <= WB_BUBBLE;
         idex_illegal <= 1'b0;
         exmem_m      <= idex_m;
         exmem_wb     <= idex_wb;
         memwb_wb     <= exmem_wb;
      end else begin
         idex_ex      <= dec_ex;
         idex_m       <= dec_m;
         idex_wb      <= dec_wb;
         idex_illegal <= dec_illegal;
         idex_rt      <= id_rt;
         exmem_m      <= idex_m;
         exmem_wb     <= idex_wb;
         memwb_wb     <= exmem_wb;
      end
   end

   assign ex_reg_dst    = idex_ex.reg_dst;
   assign ex_alu_src    = idex_ex.alu_src;
   assign ex_alu_op     = idex_ex.alu_op;
   assign ex_rt         = idex_rt;
   assign illegal_op    = idex_illegal;
   assign mem_branch    = exmem_m.branch;
   assign mem_mem_read  = exmem_m.mem_read;
   assign mem_mem_write = exmem_m.mem_write;
   assign wb_reg_write  = memwb_wb.reg_write;
   assign wb_mem_to_reg = memwb_wb.mem_to_reg;

endmodule
